// File: rtl/update_coalescer.sv
// Merges runs of same-vertex edge-update records popped from a show-ahead FIFO
// into single records with a saturating contribution sum and a merge count.
module update_coalescer #(
  parameter int unsigned ID_W    = 32,
  parameter int unsigned VAL_W   = 32,
  parameter int unsigned MAX_RUN = 15,
  parameter int unsigned CNT_W   = $clog2(MAX_RUN + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ID_W+VAL_W-1:0] fifo_q,
  input  logic                  fifo_empty,
  output logic                  fifo_rdreq,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ID_W-1:0]       out_vertex,
  output logic [VAL_W-1:0]      out_value,
  output logic [CNT_W-1:0]      out_count,
  output logic                  idle
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_RUN);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic               acc_valid_q, acc_valid_d;
  logic [ID_W-1:0]    acc_id_q,    acc_id_d;
  logic [VAL_W-1:0]   acc_sum_q,   acc_sum_d;
  logic [CNT_W-1:0]   acc_cnt_q,   acc_cnt_d;
  logic               out_valid_q, out_valid_d;
  logic [ID_W-1:0]    out_vertex_q, out_vertex_d;
  logic [VAL_W-1:0]   out_value_q,  out_value_d;
  logic [CNT_W-1:0]   out_count_q,  out_count_d;

  logic               head;
  logic [ID_W-1:0]    hid;
  logic [VAL_W-1:0]   hval;
  logic               out_free;
  logic               merge_c, close_c, load_c;
  logic [VAL_W:0]     sum_ext;
  logic [VAL_W-1:0]   sum_sat;

  // Decode the head record and the priority cases for this cycle.
  always_comb begin
    head     = !fifo_empty;
    hid      = fifo_q[ID_W+VAL_W-1:VAL_W];
    hval     = fifo_q[VAL_W-1:0];
    out_free = !out_valid_q || out_ready;
    merge_c  = acc_valid_q && !flush && head && (hid == acc_id_q) && (acc_cnt_q < CNT_MAX);
    close_c  = !merge_c && acc_valid_q &&
               (flush || (head && ((hid != acc_id_q) || (acc_cnt_q == CNT_MAX))));
    load_c   = !acc_valid_q && head;
    sum_ext  = {1'b0, acc_sum_q} + {1'b0, hval};
    sum_sat  = sum_ext[VAL_W] ? {VAL_W{1'b1}} : sum_ext[VAL_W-1:0];
  end

  // Next-state for accumulator, output register and the pop strobe.
  always_comb begin
    acc_valid_d  = acc_valid_q;
    acc_id_d     = acc_id_q;
    acc_sum_d    = acc_sum_q;
    acc_cnt_d    = acc_cnt_q;
    out_valid_d  = out_valid_q && !out_ready;
    out_vertex_d = out_vertex_q;
    out_value_d  = out_value_q;
    out_count_d  = out_count_q;
    fifo_rdreq   = 1'b0;

    if (merge_c) begin
      fifo_rdreq = 1'b1;
      acc_sum_d  = sum_sat;
      acc_cnt_d  = acc_cnt_q + CNT_ONE;
    end else if (close_c) begin
      if (out_free) begin
        out_valid_d  = 1'b1;
        out_vertex_d = acc_id_q;
        out_value_d  = acc_sum_q;
        out_count_d  = acc_cnt_q;
        if (head) begin
          fifo_rdreq = 1'b1;
          acc_id_d   = hid;
          acc_sum_d  = hval;
          acc_cnt_d  = CNT_ONE;
        end else begin
          acc_valid_d = 1'b0;
        end
      end
    end else if (load_c) begin
      fifo_rdreq  = 1'b1;
      acc_valid_d = 1'b1;
      acc_id_d    = hid;
      acc_sum_d   = hval;
      acc_cnt_d   = CNT_ONE;
    end

    // A reset cycle must never consume a FIFO entry.
    if (reset) fifo_rdreq = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_valid_q  <= 1'b0;
      acc_id_q     <= '0;
      acc_sum_q    <= '0;
      acc_cnt_q    <= '0;
      out_valid_q  <= 1'b0;
      out_vertex_q <= '0;
      out_value_q  <= '0;
      out_count_q  <= '0;
    end else begin
      acc_valid_q  <= acc_valid_d;
      acc_id_q     <= acc_id_d;
      acc_sum_q    <= acc_sum_d;
      acc_cnt_q    <= acc_cnt_d;
      out_valid_q  <= out_valid_d;
      out_vertex_q <= out_vertex_d;
      out_value_q  <= out_value_d;
      out_count_q  <= out_count_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_vertex = out_vertex_q;
  assign out_value  = out_value_q;
  assign out_count  = out_count_q;
  assign idle       = !acc_valid_q && !out_valid_q && fifo_empty;

endmodule

// File: tb/tb_update_coalescer.sv
// Directed bench for update_coalescer: a pointer-based FIFO model feeds the DUT
// and a monitor logs every accepted output record for in-order checking.
module tb_update_coalescer;

  localparam int unsigned ID_W  = 32;
  localparam int unsigned VAL_W = 32;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned REC_W = ID_W + VAL_W + CNT_W;

  logic                  clock = 1'b0;
  logic                  reset;
  logic [ID_W+VAL_W-1:0] fifo_q;
  logic                  fifo_empty;
  logic                  fifo_rdreq;
  logic                  flush;
  logic                  out_valid;
  logic                  out_ready;
  logic [ID_W-1:0]       out_vertex;
  logic [VAL_W-1:0]      out_value;
  logic [CNT_W-1:0]      out_count;
  logic                  idle;

  int vectors    = 0;
  int miscompares = 0;

  logic [ID_W+VAL_W-1:0] fifo_mem [0:63];
  int                    wr_ptr = 0;
  int                    rd_ptr = 0;
  logic [REC_W-1:0]      got_mem [0:63];
  int                    got_cnt = 0;

  update_coalescer #(.ID_W(ID_W), .VAL_W(VAL_W), .MAX_RUN(15), .CNT_W(CNT_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .fifo_q     (fifo_q),
    .fifo_empty (fifo_empty),
    .fifo_rdreq (fifo_rdreq),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_vertex (out_vertex),
    .out_value  (out_value),
    .out_count  (out_count),
    .idle       (idle)
  );

  always #5 clock = ~clock;

  assign fifo_empty = (rd_ptr == wr_ptr);
  assign fifo_q     = fifo_mem[rd_ptr[5:0]];

  always @(posedge clock) begin
    if (fifo_rdreq && !fifo_empty) rd_ptr <= rd_ptr + 1;
  end

  always @(posedge clock) begin
    if (!reset && out_valid && out_ready) begin
      got_mem[got_cnt[5:0]] <= {out_vertex, out_value, out_count};
      got_cnt <= got_cnt + 1;
    end
  end

  function automatic logic [REC_W-1:0] rec(input int unsigned id, input int unsigned val,
                                           input int unsigned cnt);
    return {ID_W'(id), VAL_W'(val), CNT_W'(cnt)};
  endfunction

  task automatic check(input string tag, input logic [REC_W-1:0] obs, input logic [REC_W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int unsigned id, input int unsigned val);
    fifo_mem[wr_ptr[5:0]] = {ID_W'(id), VAL_W'(val)};
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
  endtask

  int base;
  int p0;

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b0;
    tick(2);
    check("reset_out_valid", REC_W'(out_valid), REC_W'(0));
    check("reset_out_rec", {out_vertex, out_value, out_count}, rec(0, 0, 0));
    check("reset_idle", REC_W'(idle), REC_W'(1));
    check("reset_rdreq", REC_W'(fifo_rdreq), REC_W'(0));
    reset = 1'b0;
    tick(1);

    // Run of three, closed by a different id; the trailing record needs flush.
    base = got_cnt;
    out_ready = 1'b1;
    push(5, 10); push(5, 20); push(5, 30); push(7, 1);
    tick(8);
    check("s1_count_a", REC_W'(got_cnt - base), REC_W'(1));
    check("s1_rec_a", got_mem[base], rec(5, 60, 3));
    check("s1_no_close_on_empty", REC_W'(idle), REC_W'(0));
    do_flush();
    tick(3);
    check("s1_count_b", REC_W'(got_cnt - base), REC_W'(2));
    check("s1_rec_b", got_mem[base+1], rec(7, 1, 1));
    check("s1_idle", REC_W'(idle), REC_W'(1));
    do_flush();
    tick(2);
    check("flush_idle_noop", REC_W'(got_cnt - base), REC_W'(2));

    // MAX_RUN boundary: 17 identical records split as 15 + 2.
    base = got_cnt;
    for (int i = 0; i < 17; i++) push(9, 1);
    tick(20);
    do_flush();
    tick(3);
    check("s2_count", REC_W'(got_cnt - base), REC_W'(2));
    check("s2_rec_a", got_mem[base], rec(9, 15, 15));
    check("s2_rec_b", got_mem[base+1], rec(9, 2, 2));

    // Saturating sum.
    base = got_cnt;
    push(3, 32'hFFFF_FFF0); push(3, 32'h20);
    tick(4);
    do_flush();
    tick(3);
    check("s3_count", REC_W'(got_cnt - base), REC_W'(1));
    check("s3_sat", got_mem[base], rec(3, 32'hFFFF_FFFF, 2));

    // Backpressure: output holds, accumulator holds, no pop.
    base = got_cnt;
    out_ready = 1'b0;
    push(1, 4); push(2, 4); push(3, 4);
    tick(5);
    check("s4_hold_valid", REC_W'(out_valid), REC_W'(1));
    check("s4_hold_rec", {out_vertex, out_value, out_count}, rec(1, 4, 1));
    check("s4_no_pop", REC_W'(fifo_rdreq), REC_W'(0));
    check("s4_fifo_left", REC_W'(wr_ptr - rd_ptr), REC_W'(1));
    out_ready = 1'b1;
    #1;
    check("s4_rdreq_on_ready", REC_W'(fifo_rdreq), REC_W'(1));
    tick(3);
    do_flush();
    tick(3);
    check("s4_count", REC_W'(got_cnt - base), REC_W'(3));
    check("s4_rec_a", got_mem[base], rec(1, 4, 1));
    check("s4_rec_b", got_mem[base+1], rec(2, 4, 1));
    check("s4_rec_c", got_mem[base+2], rec(3, 4, 1));

    // Reset mid-run with a pending accumulator and a held output.
    out_ready = 1'b0;
    push(3, 1); push(4, 4); push(4, 4); push(6, 1);
    tick(5);
    check("s5_pre_rec", {out_vertex, out_value, out_count}, rec(3, 1, 1));
    p0 = rd_ptr;
    base = got_cnt;
    reset = 1'b1;
    out_ready = 1'b1;
    #1;
    check("s5_rdreq_in_reset", REC_W'(fifo_rdreq), REC_W'(0));
    tick(1);
    reset = 1'b0;
    check("s5_out_valid", REC_W'(out_valid), REC_W'(0));
    check("s5_idle", REC_W'(idle), REC_W'(fifo_empty));
    check("s5_idle_val", REC_W'(idle), REC_W'(0));
    check("s5_no_pop", REC_W'(rd_ptr - p0), REC_W'(0));
    tick(2);
    do_flush();
    tick(3);
    check("s5_count", REC_W'(got_cnt - base), REC_W'(1));
    check("s5_rec", got_mem[base], rec(6, 1, 1));

    // Alternating ids: one pop per cycle, four single-record outputs.
    base = got_cnt;
    p0 = rd_ptr;
    push(1, 1); push(2, 1); push(1, 1); push(2, 1);
    for (int k = 1; k <= 4; k++) begin
      tick(1);
      check($sformatf("s6_pops_%0d", k), REC_W'(rd_ptr - p0), REC_W'(k));
    end
    tick(2);
    do_flush();
    tick(3);
    check("s6_count", REC_W'(got_cnt - base), REC_W'(4));
    check("s6_rec_0", got_mem[base],   rec(1, 1, 1));
    check("s6_rec_1", got_mem[base+1], rec(2, 1, 1));
    check("s6_rec_2", got_mem[base+2], rec(1, 1, 1));
    check("s6_rec_3", got_mem[base+3], rec(2, 1, 1));
    check("s6_idle", REC_W'(idle), REC_W'(1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
